// File: rtl/enemy_pos_grid.sv
// enemy_pos_grid: per-slot enemy FSMs on a hole grid, plus a registered
// sprite-window lookup for the current VGA pixel.
// Optional build macro: ENEMY_FLASH_EN -- when defined, HIT sprites blink
// (shown only while countdown[0]=1); when undefined they are always shown.
module enemy_pos_grid #(
  parameter int NSLOT      = 4,
  parameter int COLS       = 3,
  parameter int ROWS       = 3,
  parameter int ORG_X      = 40,
  parameter int ORG_Y      = 50,
  parameter int STEP_X     = 170,
  parameter int STEP_Y     = 130,
  parameter int ROW_SKEW   = 25,
  parameter int CELL_W     = 160,
  parameter int CELL_H     = 120,
  parameter int HIT_FRAMES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         h_cnt,
  input  logic [9:0]         v_cnt,
  input  logic               frame_tick,
  input  logic [NSLOT-1:0]   load,
  input  logic [5*NSLOT-1:0] load_pos,
  input  logic               hit,
  input  logic [4:0]         hit_pos,
  output logic [9:0]         H,
  output logic [9:0]         V,
  output logic               pix_valid,
  output logic               pix_hit,
  output logic [2:0]         pix_slot,
  output logic [NSLOT-1:0]   active_mask,
  output logic               score_pulse,
  output logic               miss_pulse
);

  localparam int NHOLE = COLS * ROWS;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HIT    = 2'd2;

  logic [NSLOT-1:0][1:0] st_q,  st_d;
  logic [NSLOT-1:0][4:0] pos_q, pos_d;
  logic [NSLOT-1:0][7:0] cnt_q, cnt_d;
  logic [NSLOT-1:0]      active_mask_q, active_mask_d;
  logic                  score_q, score_d;
  logic                  miss_q, miss_d;
  logic [9:0]            h_q, h_d;
  logic [9:0]            v_q, v_d;
  logic                  valid_q, valid_d;
  logic                  pixhit_q, pixhit_d;
  logic [2:0]            slot_q, slot_d;

  logic                  any_match;
  logic [4:0]            ld_pos;
  logic [11:0]           hx, vy, x0, y0;
  logic                  has_hole, in_win, shown;

  // Slot FSMs: load beats hit, hit beats frame countdown; collect hit result.
  always_comb begin
    st_d          = st_q;
    pos_d         = pos_q;
    cnt_d         = cnt_q;
    any_match     = 1'b0;
    ld_pos        = 5'd0;
    active_mask_d = '0;
    for (int i = 0; i < NSLOT; i++) begin
      ld_pos = load_pos[5*i +: 5];
      if (load[i]) begin
        if (ld_pos != 5'd0 && int'(ld_pos) <= NHOLE) begin
          st_d[i]  = ST_ACTIVE;
          pos_d[i] = ld_pos;
        end else begin
          st_d[i]  = ST_EMPTY;
          pos_d[i] = 5'd0;
        end
        cnt_d[i] = 8'd0;
      end else if (hit && st_q[i] == ST_ACTIVE && pos_q[i] == hit_pos) begin
        // A tick landing on this same edge is ignored: countdown starts full.
        st_d[i]   = ST_HIT;
        cnt_d[i]  = 8'(HIT_FRAMES);
        any_match = 1'b1;
      end else if (st_q[i] == ST_HIT && frame_tick) begin
        if (cnt_q[i] <= 8'd1) begin
          st_d[i]  = ST_EMPTY;
          cnt_d[i] = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] - 8'd1;
        end
      end
      active_mask_d[i] = (st_d[i] == ST_ACTIVE);
    end
    score_d = hit && any_match;
    miss_d  = hit && !any_match;
  end

  // Pixel lookup: scan slots from highest to lowest so the lowest index wins.
  always_comb begin
    h_d      = 10'd0;
    v_d      = 10'd0;
    valid_d  = 1'b0;
    pixhit_d = 1'b0;
    slot_d   = 3'd0;
    hx       = {2'b00, h_cnt};
    vy       = {2'b00, v_cnt};
    x0       = 12'd0;
    y0       = 12'd0;
    has_hole = 1'b0;
    in_win   = 1'b0;
    shown    = 1'b0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      x0       = 12'd0;
      y0       = 12'd0;
      has_hole = 1'b0;
      for (int k = 1; k <= NHOLE; k++) begin
        if (pos_q[i] == 5'(k)) begin
          x0       = 12'(ORG_X + ((k - 1) / COLS) * ROW_SKEW + ((k - 1) % COLS) * STEP_X);
          y0       = 12'(ORG_Y + ((k - 1) / COLS) * STEP_Y);
          has_hole = 1'b1;
        end
      end
      in_win = has_hole && (hx > x0) && (hx < x0 + 12'(CELL_W)) &&
               (vy > y0) && (vy < y0 + 12'(CELL_H));
`ifdef ENEMY_FLASH_EN
      shown = (st_q[i] == ST_ACTIVE) || (st_q[i] == ST_HIT && cnt_q[i][0]);
`else
      shown = (st_q[i] == ST_ACTIVE) || (st_q[i] == ST_HIT);
`endif
      if (shown && in_win) begin
        h_d      = 10'(hx - x0);
        v_d      = 10'(vy - y0);
        valid_d  = 1'b1;
        pixhit_d = (st_q[i] == ST_HIT);
        slot_d   = 3'(i);
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q          <= '0;
      pos_q         <= '0;
      cnt_q         <= '0;
      active_mask_q <= '0;
      score_q       <= 1'b0;
      miss_q        <= 1'b0;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      valid_q       <= 1'b0;
      pixhit_q      <= 1'b0;
      slot_q        <= 3'd0;
    end else begin
      st_q          <= st_d;
      pos_q         <= pos_d;
      cnt_q         <= cnt_d;
      active_mask_q <= active_mask_d;
      score_q       <= score_d;
      miss_q        <= miss_d;
      h_q           <= h_d;
      v_q           <= v_d;
      valid_q       <= valid_d;
      pixhit_q      <= pixhit_d;
      slot_q        <= slot_d;
    end
  end

  assign H           = h_q;
  assign V           = v_q;
  assign pix_valid   = valid_q;
  assign pix_hit     = pixhit_q;
  assign pix_slot    = slot_q;
  assign active_mask = active_mask_q;
  assign score_pulse = score_q;
  assign miss_pulse  = miss_q;

endmodule
